// File: rtl/packet_rr_scheduler.sv
// Packet-level round-robin scheduler: one grant held per packet, priority rotates on release.
// Define PRS_WATCHDOG_EN to build the stall watchdog that force-releases a starved grant.
module packet_rr_scheduler #(
    parameter int CHANNEL_NUMBER   = 5,
    parameter int MAX_PACKET_BEATS = 16,
    parameter int WATCHDOG_CYCLES  = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [CHANNEL_NUMBER-1:0]         req_valid_i,
    input  logic [CHANNEL_NUMBER-1:0]         req_last_i,
    input  logic                              out_ready_i,
    output logic                              out_valid_o,
    output logic [CHANNEL_NUMBER-1:0]         in_ready_o,
    output logic [CHANNEL_NUMBER-1:0]         grant_o,
    output logic [$clog2(CHANNEL_NUMBER)-1:0] grant_idx_o,
    output logic                              locked_o,
    output logic                              overlength_o,
    output logic                              timeout_o
);
    localparam int IDX_W  = $clog2(CHANNEL_NUMBER);
    localparam int BEAT_W = $clog2(MAX_PACKET_BEATS + 1);
    localparam logic [BEAT_W-1:0] BEAT_LIMIT = BEAT_W'(MAX_PACKET_BEATS - 1);
    localparam logic [IDX_W-1:0]  PTR_RST    = IDX_W'(CHANNEL_NUMBER - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d, idx_d;
    logic [CHANNEL_NUMBER-1:0] grant_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic                      ovl_d;
    logic                      xfer, last_sel;

`ifdef PRS_WATCHDOG_EN
    localparam int STALL_W = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(WATCHDOG_CYCLES - 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               tmo_q, tmo_d;

    assign timeout_o = tmo_q;
`else
    assign timeout_o = 1'b0;
`endif

    // First requester strictly after base, wrapping; the descending loop leaves the nearest one.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [CHANNEL_NUMBER-1:0] req,
                                                 input logic [IDX_W-1:0]          base);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        pick = base;
        for (int k = CHANNEL_NUMBER; k >= 1; k--) begin
            cand = IDX_W'((int'(base) + k) % CHANNEL_NUMBER);
            if (req[cand]) pick = cand;
        end
        return pick;
    endfunction

    // grant_o is one-hot or zero, so masking replaces an indexed select of the granted lane.
    assign out_valid_o = |(req_valid_i & grant_o);
    assign last_sel    = |(req_last_i & grant_o);
    assign in_ready_o  = grant_o & {CHANNEL_NUMBER{out_ready_i}};
    assign xfer        = out_valid_o & out_ready_i;
    assign locked_o    = (state_q == BUSY);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = grant_idx_o;
        grant_d = grant_o;
        beat_d  = beat_q;
        ovl_d   = 1'b0;
`ifdef PRS_WATCHDOG_EN
        stall_d = stall_q;
        tmo_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    idx_d          = rr_pick(req_valid_i, ptr_q);
                    grant_d        = '0;
                    grant_d[idx_d] = 1'b1;
                    beat_d         = '0;
`ifdef PRS_WATCHDOG_EN
                    stall_d        = '0;
`endif
                    state_d        = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    beat_d = beat_q + BEAT_W'(1);
`ifdef PRS_WATCHDOG_EN
                    stall_d = '0;
`endif
                    if (last_sel || (beat_q == BEAT_LIMIT)) begin
                        ovl_d   = ~last_sel;
                        ptr_d   = grant_idx_o;
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
`ifdef PRS_WATCHDOG_EN
                else if (!out_valid_o) begin
                    // Only upstream starvation counts; downstream backpressure is legitimate.
                    if (stall_q == STALL_LIMIT) begin
                        tmo_d   = 1'b1;
                        ptr_d   = grant_idx_o;
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        stall_d = stall_q + STALL_W'(1);
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            ptr_q        <= PTR_RST;
            grant_o      <= '0;
            grant_idx_o  <= '0;
            beat_q       <= '0;
            overlength_o <= 1'b0;
`ifdef PRS_WATCHDOG_EN
            stall_q      <= '0;
            tmo_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_o      <= grant_d;
            grant_idx_o  <= idx_d;
            beat_q       <= beat_d;
            overlength_o <= ovl_d;
`ifdef PRS_WATCHDOG_EN
            stall_q      <= stall_d;
            tmo_q        <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_packet_rr_scheduler.sv
// Bench for packet_rr_scheduler: directed scenarios plus randomized traffic against a packet-level model.
module tb_packet_rr_scheduler;
    localparam int N    = 5;
    localparam int MAXB = 4;
    localparam int WD   = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_valid, req_last;
    logic         out_ready;
    logic         out_valid;
    logic [N-1:0] in_ready, grant;
    logic [2:0]   grant_idx;
    logic         locked, overlength, timeout;

    int total = 0;
    int bad   = 0;
    int cycle_no = 0;

    int src_en[N], src_len[N], src_beat[N], src_xfer[N];

    packet_rr_scheduler #(
        .CHANNEL_NUMBER  (N),
        .MAX_PACKET_BEATS(MAXB),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_last_i  (req_last),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .in_ready_o  (in_ready),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .locked_o    (locked),
        .overlength_o(overlength),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_no <= cycle_no + 1;

    function automatic logic bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    // Packet-level reference: who owns the path, how many beats it moved, where priority restarts.
    int   m_busy, m_ch, m_beats, m_ptr, m_stall, m_found;
    logic m_ovl, m_tmo;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_ch = 0; m_beats = 0; m_ptr = N - 1; m_stall = 0;
            m_ovl = 1'b0; m_tmo = 1'b0;
        end else begin
            m_ovl = 1'b0;
            m_tmo = 1'b0;
            if (m_busy == 0) begin
                m_found = 0;
                for (int k = 1; k <= N; k++)
                    if (m_found == 0 && bit_of(req_valid, (m_ptr + k) % N)) begin
                        m_found = 1;
                        m_ch    = (m_ptr + k) % N;
                    end
                if (m_found != 0) begin
                    m_busy = 1; m_beats = 0; m_stall = 0;
                end
            end else if (bit_of(req_valid, m_ch) && out_ready) begin
                m_beats = m_beats + 1;
                m_stall = 0;
                if (bit_of(req_last, m_ch) || m_beats == MAXB) begin
                    m_busy = 0;
                    m_ptr  = m_ch;
                    m_ovl  = !bit_of(req_last, m_ch);
                end
            end
`ifdef PRS_WATCHDOG_EN
            else if (!bit_of(req_valid, m_ch)) begin
                m_stall = m_stall + 1;
                if (m_stall == WD) begin
                    m_busy = 0;
                    m_ptr  = m_ch;
                    m_tmo  = 1'b1;
                end
            end
`endif
        end
    end

    task automatic drive_src();
        req_valid = '0;
        req_last  = '0;
        for (int c = 0; c < N; c++) begin
            if (src_en[c] != 0) req_valid = req_valid | (N'(1) << c);
            if (src_en[c] != 0 && src_beat[c] == src_len[c] - 1) req_last = req_last | (N'(1) << c);
        end
    endtask

    task automatic clear_src();
        for (int c = 0; c < N; c++) begin
            src_en[c] = 0; src_len[c] = 2; src_beat[c] = 0; src_xfer[c] = 0;
        end
    endtask

    // One clock: sources advance on the handshakes seen before the edge, then re-drive.
    task automatic tick();
        logic [N-1:0] hs;
        drive_src();
        #1;
        hs = in_ready & req_valid;
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++)
            if (bit_of(hs, c)) begin
                src_xfer[c] = src_xfer[c] + 1;
                src_beat[c] = (src_beat[c] + 1 == src_len[c]) ? 0 : src_beat[c] + 1;
            end
        drive_src();
        #1;
    endtask

    task automatic apply_reset();
        clear_src();
        out_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_locked();
        for (int i = 0; i < 20 && locked !== 1'b1; i++) tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && locked !== 1'b0; i++) tick();
    endtask

    task automatic test_reset();
        clear_src();
        for (int c = 0; c < N; c++) src_en[c] = 1;
        out_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (grant !== '0)       begin bad++; $display("FAIL reset_grant: got %b want 0", grant); end
        total++; if (grant_idx !== 3'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", grant_idx); end
        total++; if (locked !== 1'b0)    begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== '0)    begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        total++; if (overlength !== 1'b0) begin bad++; $display("FAIL reset_overlength: got %b want 0", overlength); end
        total++; if (timeout !== 1'b0)   begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        clear_src();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_fairness();
        int order[$];
        int when[$];
        int exp_order[6];
        logic [N-1:0] prev;
        exp_order = '{0, 2, 3, 0, 2, 3};
        apply_reset();
        src_en[0] = 1; src_en[2] = 1; src_en[3] = 1;
        prev = '0;
        for (int i = 0; i < 60 && order.size() < 6; i++) begin
            tick();
            if (grant !== '0 && grant !== prev) begin
                order.push_back(int'(grant_idx));
                when.push_back(cycle_no);
            end
            prev = grant;
        end
        total++;
        if (order.size() != 6) begin
            bad++; $display("FAIL fair_grant_count: got %0d grants want 6", order.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (order[i] != exp_order[i]) begin
                    bad++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, order[i], exp_order[i]);
                end
            end
            for (int i = 1; i < 6; i++) begin
                total++;
                if (when[i] - when[i-1] != 3) begin
                    bad++; $display("FAIL fair_spacing[%0d]: got %0d cycles want 3", i, when[i] - when[i-1]);
                end
            end
        end
        clear_src();
        wait_idle();
    endtask

    task automatic test_lock();
        int held;
        apply_reset();
        src_en[1] = 1; src_len[1] = 3;
        wait_locked();
        total++; if (locked !== 1'b1 || grant_idx !== 3'd1) begin
            bad++; $display("FAIL lock_first: got locked=%b idx=%0d want 1/1", locked, grant_idx);
        end
        src_en[4] = 1; src_len[4] = 2;
        held = 0;
        for (int i = 0; i < 20 && locked === 1'b1; i++) begin
            total++; if (grant_idx !== 3'd1) begin
                bad++; $display("FAIL lock_hold: got idx=%0d want 1", grant_idx);
            end
            held++;
            tick();
        end
        total++; if (held != 3) begin bad++; $display("FAIL lock_len: got %0d cycles want 3", held); end
        total++; if (src_xfer[1] != 3) begin bad++; $display("FAIL lock_beats: got %0d want 3", src_xfer[1]); end
        tick();
        total++; if (grant !== 5'b10000 || grant_idx !== 3'd4) begin
            bad++; $display("FAIL lock_next: got grant=%b idx=%0d want 10000/4", grant, grant_idx);
        end
        clear_src();
        wait_idle();
    endtask

    task automatic test_backpressure();
        int c_start;
        apply_reset();
        src_en[2] = 1; src_len[2] = 3;
        wait_locked();
        c_start = cycle_no;
        tick();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            total++; if (in_ready !== '0 || locked !== 1'b1 || out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_stall: got in_ready=%b locked=%b valid=%b want 0/1/1", in_ready, locked, out_valid);
            end
            tick();
        end
        out_ready = 1'b1;
        src_en[2] = 0;
        src_en[2] = 1;
        for (int i = 0; i < 20 && locked === 1'b1; i++) tick();
        total++; if (cycle_no - c_start != 8) begin
            bad++; $display("FAIL bp_duration: got %0d cycles want 8", cycle_no - c_start);
        end
        total++; if (src_xfer[2] != 3) begin bad++; $display("FAIL bp_beats: got %0d want 3", src_xfer[2]); end
        clear_src();
        wait_idle();
    endtask

    task automatic test_overlength();
        int c_start;
        apply_reset();
        src_en[0] = 1; src_len[0] = 6;
        wait_locked();
        c_start = cycle_no;
        for (int i = 0; i < 20 && locked === 1'b1; i++) tick();
        total++; if (cycle_no - c_start != MAXB) begin
            bad++; $display("FAIL ovl_len: got %0d beats want %0d", cycle_no - c_start, MAXB);
        end
        total++; if (overlength !== 1'b1) begin bad++; $display("FAIL ovl_pulse: got %b want 1", overlength); end
        total++; if (src_xfer[0] != MAXB) begin bad++; $display("FAIL ovl_beats: got %0d want %0d", src_xfer[0], MAXB); end
        tick();
        total++; if (overlength !== 1'b0 || locked !== 1'b1 || grant_idx !== 3'd0) begin
            bad++; $display("FAIL ovl_rearb: got ovl=%b locked=%b idx=%0d want 0/1/0", overlength, locked, grant_idx);
        end
        for (int i = 0; i < 20 && locked === 1'b1; i++) tick();
        total++; if (overlength !== 1'b0 || src_xfer[0] != 6) begin
            bad++; $display("FAIL ovl_tail: got ovl=%b beats=%0d want 0/6", overlength, src_xfer[0]);
        end
        clear_src();
        wait_idle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        src_en[0] = 1; src_en[3] = 1; src_len[0] = 4; src_len[3] = 4;
        wait_locked();
        tick();
        rst_n = 1'b0;
        tick();
        total++; if (grant !== '0 || grant_idx !== 3'd0 || locked !== 1'b0) begin
            bad++; $display("FAIL rstmid_state: got grant=%b idx=%0d locked=%b want 0/0/0", grant, grant_idx, locked);
        end
        total++; if (out_valid !== 1'b0 || in_ready !== '0 || overlength !== 1'b0 || timeout !== 1'b0) begin
            bad++; $display("FAIL rstmid_outs: got valid=%b ready=%b ovl=%b tmo=%b want 0", out_valid, in_ready, overlength, timeout);
        end
        rst_n = 1'b1;
        for (int c = 0; c < N; c++) src_beat[c] = 0;
        tick();
        total++; if (grant !== 5'b00001 || grant_idx !== 3'd0) begin
            bad++; $display("FAIL rstmid_regrant: got grant=%b idx=%0d want 00001/0", grant, grant_idx);
        end
        clear_src();
        wait_idle();
    endtask

    task automatic test_watchdog();
        int stalls;
        apply_reset();
        src_en[1] = 1; src_en[3] = 1; src_len[1] = 4; src_len[3] = 4;
        wait_locked();
        total++; if (grant_idx !== 3'd1) begin bad++; $display("FAIL wd_first: got %0d want 1", grant_idx); end
        src_en[1] = 0;
        drive_src();
        #1;
`ifdef PRS_WATCHDOG_EN
        stalls = 0;
        for (int i = 0; i < 40 && locked === 1'b1; i++) begin
            if (out_valid === 1'b0) stalls++;
            tick();
        end
        total++; if (stalls != WD) begin bad++; $display("FAIL wd_stalls: got %0d want %0d", stalls, WD); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL wd_pulse: got %b want 1", timeout); end
        tick();
        total++; if (timeout !== 1'b0 || grant_idx !== 3'd3 || locked !== 1'b1) begin
            bad++; $display("FAIL wd_next: got tmo=%b idx=%0d locked=%b want 0/3/1", timeout, grant_idx, locked);
        end
`else
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            total++; if (locked !== 1'b1 || grant_idx !== 3'd1 || timeout !== 1'b0) begin
                bad++; $display("FAIL wd_hold: got locked=%b idx=%0d tmo=%b want 1/1/0", locked, grant_idx, timeout);
            end
            stalls++;
            tick();
        end
        src_en[1] = 1;
`endif
        for (int i = 0; i < 40 && locked === 1'b1; i++) tick();
        clear_src();
        wait_idle();
    endtask

    task automatic test_random();
        logic [N-1:0] eg, er;
        logic         ev;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 79) != 0);
            req_valid = N'($urandom);
            req_last  = N'($urandom) & N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            eg = (m_busy != 0) ? (N'(1) << m_ch) : '0;
            ev = (m_busy != 0) && bit_of(req_valid, m_ch);
            er = eg & {N{out_ready}};
            total++; if (grant !== eg) begin bad++; $display("FAIL rnd_grant@%0d: got %b want %b", i, grant, eg); end
            total++; if (locked !== (m_busy != 0)) begin bad++; $display("FAIL rnd_locked@%0d: got %b want %0d", i, locked, m_busy); end
            total++; if (out_valid !== ev) begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", i, out_valid, ev); end
            total++; if (in_ready !== er) begin bad++; $display("FAIL rnd_ready@%0d: got %b want %b", i, in_ready, er); end
            total++; if (overlength !== m_ovl) begin bad++; $display("FAIL rnd_ovl@%0d: got %b want %b", i, overlength, m_ovl); end
            total++; if (timeout !== m_tmo) begin bad++; $display("FAIL rnd_tmo@%0d: got %b want %b", i, timeout, m_tmo); end
            if (m_busy != 0) begin
                total++; if (grant_idx !== 3'(m_ch)) begin bad++; $display("FAIL rnd_idx@%0d: got %0d want %0d", i, grant_idx, m_ch); end
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        clear_src();
        drive_src();
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        req_valid = '0;
        req_last  = '0;
        clear_src();
        test_reset();
        test_fairness();
        test_lock();
        test_backpressure();
        test_overlength();
        test_reset_mid();
        test_watchdog();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
